// File: rtl/alu_seq_pkg.sv
// Shared definitions for the FP ALU command sequencer.
//   - opcode encodings, flag bit positions and the illegal-op flag pattern
//   - FSM state encoding
//   - canonical quiet-NaN results for SP and HP
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Flag vector layout: {invalid, div0, ovf, unf, inexact}
    localparam int unsigned FLAG_INVALID = 4;
    localparam int unsigned FLAG_DIV0    = 3;
    localparam int unsigned FLAG_OVF     = 2;
    localparam int unsigned FLAG_UNF     = 1;
    localparam int unsigned FLAG_INEXACT = 0;

    localparam logic [4:0] FLAGS_ILLEGAL = 5'b10000;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] QNAN_HP = 32'h0000_7E00;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StRelease = 2'd2,
        StResp    = 2'd3
    } seq_state_e;

    // Opcodes 100-111 are reserved.
    function automatic logic op_is_legal(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic [31:0] qnan_for(input logic mode_sp);
        return mode_sp ? QNAN_SP : QNAN_HP;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the FP ALU start/valid_out handshake.
// Accepts one command at a time on a valid/ready port, runs it on the ALU, and
// returns result, flags and tag on a valid/ready response port. Illegal opcodes
// are answered directly with a qNaN and the invalid flag; an op that does not
// complete within TIMEOUT_CYCLES is aborted and reported with rsp_timeout.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_a, cmd_b, cmd_op,
//   cmd_mode, cmd_round, cmd_tag   command payload (mode 1=SP, 0=HP)
//   alu_op_a/_b, alu_op_code,
//   alu_mode_fp, alu_round_mode    registered operands to the ALU
//   alu_start                      ALU start request
//   alu_result, alu_valid_out,
//   alu_flags                      ALU completion
//   rsp_valid/rsp_ready            response handshake
//   rsp_result, rsp_flags,
//   rsp_tag, rsp_timeout           response payload
//   busy                           sequencer not idle
//
// Optional build macro ALU_SEQ_STICKY_FLAGS_EN adds sticky_clr (in) and
// sticky_flags (out): an OR-accumulation of rsp_flags over completed
// non-timeout responses.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_mode,
    input  logic             cmd_round,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_op_a,
    output logic [31:0]      alu_op_b,
    output logic [2:0]       alu_op_code,
    output logic             alu_mode_fp,
    output logic             alu_round_mode,
    output logic             alu_start,
    input  logic [31:0]      alu_result,
    input  logic             alu_valid_out,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic             sticky_clr,
    output logic [4:0]       sticky_flags
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start_d;
    logic             accept;
    logic             capture;
    logic             abort;
    logic             rsp_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = alu_start;
        accept   = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        rsp_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (op_is_legal(cmd_op)) begin
                        state_d = StIssue;
                        start_d = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                // Completion takes priority over a timeout in the same cycle.
                if (alu_valid_out) begin
                    capture = 1'b1;
                    start_d = 1'b0;
                    state_d = StRelease;
                end else if (cnt_q == CNT_MAX) begin
                    abort   = 1'b1;
                    start_d = 1'b0;
                    state_d = StResp;
                end
            end
            StRelease: begin
                // Hold off until the ALU drops valid_out so the next start
                // can never overlap the previous completion.
                if (!alu_valid_out) begin
                    state_d = StResp;
                end else if (cnt_q == CNT_MAX) begin
                    abort   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gated by rst so the port reads 0 while reset is held.
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Timeout counter: saturates so a late valid_out in RELEASE still
    // sees the budget as exhausted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if ((state_q == StIssue || state_q == StRelease) && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ALU drive and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= 1'b0;
            alu_start      <= 1'b0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
            rsp_tag        <= '0;
            rsp_timeout    <= 1'b0;
        end else begin
            alu_start <= start_d;
            if (accept) begin
                alu_op_a       <= cmd_a;
                alu_op_b       <= cmd_b;
                alu_op_code    <= cmd_op;
                alu_mode_fp    <= cmd_mode;
                alu_round_mode <= cmd_round;
                rsp_tag        <= cmd_tag;
                rsp_timeout    <= 1'b0;
                if (!op_is_legal(cmd_op)) begin
                    rsp_result <= qnan_for(cmd_mode);
                    rsp_flags  <= FLAGS_ILLEGAL;
                end
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
            if (abort) begin
                rsp_result  <= '0;
                rsp_flags   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // A flag set in the same cycle as a clear survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (rsp_done && !rsp_timeout) begin
            sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) | rsp_flags;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned TMO   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [2:0]       cmd_op = '0;
    logic             cmd_mode = 1'b0;
    logic             cmd_round = 1'b0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [31:0]      alu_op_a;
    logic [31:0]      alu_op_b;
    logic [2:0]       alu_op_code;
    logic             alu_mode_fp;
    logic             alu_round_mode;
    logic             alu_start;
    logic [31:0]      alu_result = '0;
    logic             alu_valid_out = 1'b0;
    logic [4:0]       alu_flags = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    alu_cmd_sequencer #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_op         (cmd_op),
        .cmd_mode       (cmd_mode),
        .cmd_round      (cmd_round),
        .cmd_tag        (cmd_tag),
        .alu_op_a       (alu_op_a),
        .alu_op_b       (alu_op_b),
        .alu_op_code    (alu_op_code),
        .alu_mode_fp    (alu_mode_fp),
        .alu_round_mode (alu_round_mode),
        .alu_start      (alu_start),
        .alu_result     (alu_result),
        .alu_valid_out  (alu_valid_out),
        .alu_flags      (alu_flags),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_flags      (rsp_flags),
        .rsp_tag        (rsp_tag),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in ALU arithmetic: the known vectors give real FP answers,
    // everything else an arbitrary but deterministic pattern. Returns {flags, result}.
    function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic mode);
        if (mode && op == 3'd0 && a == 32'h4040_0000 && b == 32'h4000_0000)
            return {5'b00000, 32'h40A0_0000};
        if (!mode && op == 3'd0 && a[15:0] == 16'h3C00 && b[15:0] == 16'h3C00)
            return {5'b00000, a[31:16], 16'h4000};
        if (mode && op == 3'd3 && a == 32'h3F80_0000 && b == 32'h0)
            return {5'b01000, 32'h7F80_0000};
        return {a[4:0] ^ b[9:5] ^ {2'b00, op}, (a ^ {b[15:0], b[31:16]}) + {28'd0, op, mode}};
    endfunction

    // ------------------------------------------------------------------
    // Stub ALU, evaluated on the falling edge. valid_out rises on the
    // alu_lat-th falling edge that sees start high, and falls alu_hold
    // falling edges after start is seen low.
    // ------------------------------------------------------------------
    int          alu_lat = 1;
    int          alu_hold = 0;
    bit          alu_stuck = 1'b0;
    bit          alu_busy = 1'b0;
    int          alu_cyc = 0;
    int          alu_hold_cnt = 0;
    int          start_rises = 0;
    int          start_hi = 0;
    logic        start_prev = 1'b0;
    logic [68:0] alu_in_lat;

    always @(negedge clk) begin
        if (rst) begin
            alu_valid_out = 1'b0;
            alu_busy      = 1'b0;
            start_prev    = 1'b0;
        end else begin
            if (alu_start && !start_prev) begin
                start_rises++;
                check_eq("no_start_while_valid", alu_valid_out, 1'b0);
            end
            start_prev = alu_start;
            if (alu_start) start_hi++;
            if (!alu_busy && alu_start) begin
                alu_busy   = 1'b1;
                alu_cyc    = 0;
                alu_in_lat = {alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode};
            end
            if (alu_busy && alu_start)
                check_eq("alu_in_stable",
                         {alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode},
                         alu_in_lat);
            if (alu_busy && alu_start && !alu_valid_out) begin
                alu_cyc++;
                if (!alu_stuck && alu_cyc == alu_lat) begin
                    {alu_flags, alu_result} = alu_fn(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp);
                    alu_valid_out = 1'b1;
                    alu_hold_cnt  = alu_hold;
                end
            end else if (alu_busy && !alu_start) begin
                if (!alu_valid_out) begin
                    alu_busy = 1'b0;
                end else if (alu_hold_cnt == 0) begin
                    alu_valid_out = 1'b0;
                    alu_busy      = 1'b0;
                    alu_result    = $urandom;
                    alu_flags     = 5'($urandom);
                end else begin
                    alu_hold_cnt--;
                end
            end
        end
    end

    // Present a command and complete the handshake; ok=0 if never accepted.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic mode, input logic rnd, input logic [TAG_W-1:0] tag,
                            output bit ok);
        int g;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_mode = mode; cmd_round = rnd; cmd_tag = tag;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_eq("cmd_ready", cmd_ready, 1'b1);
        ok = cmd_ready;
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    // Count falling edges after the accepting edge until rsp_valid shows.
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
        end while (!rsp_valid && n < 200);
        check_eq("rsp_valid", rsp_valid, 1'b1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic mode, input logic rnd, input logic [TAG_W-1:0] tag,
                          input int lat, input int hold, input int rdly, input bit stuck);
        logic [36:0] exp;
        bit          exp_to;
        int          exp_n;
        int          exp_hi;
        int          exp_rises;
        int          n;
        bit          ok;
        alu_lat = lat; alu_hold = hold; alu_stuck = stuck;
        start_rises = 0; start_hi = 0;
        if (op >= 3'd4) begin
            exp = {5'b10000, mode ? 32'h7FC0_0000 : 32'h0000_7E00};
            exp_to = 1'b0; exp_n = 1; exp_hi = 0; exp_rises = 0;
        end else if (stuck || lat > int'(TMO)) begin
            exp = '0;
            exp_to = 1'b1; exp_n = TMO + 1; exp_hi = TMO; exp_rises = 1;
        end else begin
            exp = alu_fn(a, b, op, mode);
            exp_to = 1'b0; exp_n = lat + 2 + hold; exp_hi = lat; exp_rises = 1;
        end
        send_cmd(a, b, op, mode, rnd, tag, ok);
        if (!ok) return;
        wait_rsp(n);
        check_eq("rsp_latency", n, exp_n);
        if (!rsp_valid) return;
        for (int i = 0; i <= rdly; i++) begin
            check_eq("rsp_result", rsp_result, exp[31:0]);
            check_eq("rsp_flags", rsp_flags, exp[36:32]);
            check_eq("rsp_tag", rsp_tag, tag);
            check_eq("rsp_timeout", rsp_timeout, exp_to);
            check_eq("start_low_in_rsp", alu_start, 1'b0);
            check_eq("busy_in_rsp", busy, 1'b1);
            if (i < rdly) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_after_hs", rsp_valid, 1'b0);
        check_eq("busy_after_hs", busy, 1'b0);
        check_eq("cmd_ready_after_hs", cmd_ready, 1'b1);
        check_eq("start_rises", start_rises, exp_rises);
        check_eq("start_hi_cycles", start_hi, exp_hi);
    endtask

    initial begin
        int          n;
        bit          ok;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        #2 rst = 1'b1;
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_alu_start", alu_start, 1'b0);
        check_eq("rst_outs", {alu_op_a, alu_op_b, alu_op_code, rsp_result, rsp_flags,
                              rsp_tag, rsp_timeout}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Known-answer operations
        run_op(32'h4040_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0, 4'd5, 3, 0, 0, 1'b0);
        run_op(32'h0000_3C00, 32'h0000_3C00, 3'd0, 1'b0, 1'b1, 4'd2, 2, 1, 1, 1'b0);
        run_op(32'h3F80_0000, 32'h0000_0000, 3'd3, 1'b1, 1'b0, 4'd9, 4, 0, 2, 1'b0);
        // Illegal opcodes, SP and HP NaN
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd7, 1'b1, 1'b0, 4'd3, 1, 0, 0, 1'b0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd4, 1'b0, 1'b0, 4'd4, 1, 0, 1, 1'b0);
        // Timeout: ALU never answers
        run_op(32'hAAAA_0001, 32'h5555_0002, 3'd2, 1'b1, 1'b0, 4'd6, 1, 0, 0, 1'b1);
        // Completion in the last budget cycle wins; one cycle later it is a timeout
        run_op(32'h0BAD_F00D, 32'h0000_1111, 3'd1, 1'b1, 1'b0, 4'd7, TMO, 0, 0, 1'b0);
        run_op(32'h0BAD_F00D, 32'h0000_2222, 3'd1, 1'b1, 1'b0, 4'd8, TMO + 1, 0, 0, 1'b0);
        // Minimum-latency op
        run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'd2, 1'b0, 1'b0, 4'd1, 1, 0, 0, 1'b0);

        // Response stalled 20 cycles, then reset discards it
        alu_lat = 2; alu_hold = 0; alu_stuck = 1'b0;
        send_cmd(32'h4040_0000, 32'h4000_0000, 3'd0, 1'b1, 1'b0, 4'hC, ok);
        if (ok) begin
            wait_rsp(n);
            for (int i = 0; i < 20; i++) begin
                check_eq("stall_result", rsp_result, 32'h40A0_0000);
                check_eq("stall_tag", rsp_tag, 4'hC);
                check_eq("stall_valid", rsp_valid, 1'b1);
                @(negedge clk);
            end
        end
        rst = 1'b1;
        #1;
        check_eq("rst_drop_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_drop_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", cmd_ready, 1'b1);

        // Reset mid-operation drops alu_start at once
        alu_stuck = 1'b1;
        send_cmd(32'h1, 32'h2, 3'd0, 1'b1, 1'b0, 4'h1, ok);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("midop_start_high", alu_start, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("midop_rst_start", alu_start, 1'b0);
        check_eq("midop_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        alu_stuck = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            run_op(ra, rb, rop, 1'($urandom), 1'($urandom), 4'($urandom),
                   $urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
